i2s_tx_stereo16: RTL and testbench
==================================

Name: i2s_tx_stereo16

Overview:
- I2S master transmitter: the playback counterpart of the team's PCM1808 receive path.
- Generates BCK and LRCK from the system clock and shifts 16-bit stereo samples MSB-first to an external DAC (PCM5102-class, Philips I2S, one-BCK data delay).
- Stereo sample pairs enter through a valid/ready handshake into a one-entry holding register; a shifter drains it once per frame.

Parameters:
- BCK_DIV, 4: clk cycles per BCK half-period (≥2); BCK period = 2*BCK_DIV clk.
- SLOT_BITS, 32: BCK cycles per channel slot (≥ DATA_BITS+1).
- DATA_BITS, 16: sample width.
- LEFT_LEVEL, 1'b0: LRCK level during the left slot.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- tx_en  in  1  run enable.
- in_valid  in  1  sample pair valid.
- in_left  in  16  left sample, two's complement.
- in_right  in  16  right sample.
- in_ready  out  1  holding register empty.
- bck  out  1  bit clock to DAC.
- lrck  out  1  word select to DAC.
- sdata  out  1  serial data to DAC.
- frame_load  out  1  1-clk pulse: a frame was loaded into the shifter.
- underrun  out  1  1-clk pulse: frame started with the holding register empty.

Behaviour:
- Reset, asynchronous: bck=0, lrck=~LEFT_LEVEL, sdata=0, in_ready=1, frame_load=0, underrun=0, holding register empty, all counters 0.
- Accept: a pair is accepted when in_valid & in_ready at a clk edge. in_ready is registered and falls the cycle after the accept. Data must be held while in_valid=1 & in_ready=0.
- Divider:
  - Counts 0..BCK_DIV-1 while tx_en=1.
  - bck toggles on wrap.
  - "fall event" = the clk cycle where bck goes 1→0. All lrck/sdata updates happen only on fall events, so the DAC samples on the BCK rising edge.
- Bit index b runs 0..SLOT_BITS-1 per slot; the slot alternates left/right.
- At b=0: lrck takes the new slot level and sdata=0.
  - b=1..DATA_BITS: sdata = sample[DATA_BITS-b] (MSB at b=1).
  - b>DATA_BITS: sdata=0.
- Frame load, at the fall event with b=0 of the left slot:
  - Holding register full: copy left/right into the shifter, empty the holding register, pulse frame_load. in_ready=1 on the next clk.
  - Holding register empty: the shifter takes zeros and underrun pulses.
- Accept in the same cycle as an empty-register load: counts as underrun. The accepted pair waits for the next frame.
- Start: on tx_en rising, the first fall event (BCK_DIV clk after bck rises) starts the left slot at b=0. The first bck rise is BCK_DIV clk after tx_en=1.
- tx_en low mid-frame takes effect on the next clk:
  - bck=0, lrck=~LEFT_LEVEL, sdata=0.
  - Divider, b and slot reset.
  - Holding register and its handshake are retained; the shifter is discarded.
- Frame length = 2*SLOT_BITS*2*BCK_DIV clk (512 at defaults).

Optional Feature:
- Macro I2S_TX_HOLD_LAST_EN.
- Defined: on underrun the shifter reloads the last successfully loaded pair (reset value 0); the underrun pulse is still generated.
- Undefined: underrun transmits zeros.

Decomposition:
- Shared package i2s_pkg holds:
  - localparams: default DATA_BITS/SLOT_BITS, LEFT_LEVEL.
  - typedef stereo_sample_t {left,right} of DATA_BITS each.
  - slot enum {SLOT_LEFT, SLOT_RIGHT}.
- One sub-module, i2s_clk_gen: divider + bit/slot counters, outputs bck, lrck, fall_evt, bit_idx, slot.
- The top level holds the handshake, holding register and shifter.

Test Plan:
- Single pair L=16'hA5C3, R=16'h0F0F, defaults: decode on bck rising edges. Left slot bits 1–16 = A5C3 with bits 17–31 = 0. Right slot bits 1–16 = 0F0F. One frame_load pulse, no underrun.
- Back-to-back stream of 4 pairs with in_valid held high: in_ready goes 0 after each accept. One accept per 512 clk. Pairs appear in order, no gaps, no underrun.
- No input after the first frame: the second frame transmits all zeros and pulses underrun once per frame. With I2S_TX_HOLD_LAST_EN it repeats A5C3/0F0F instead.
- tx_en deasserted at bit 7 of the left slot: next clk bck=0, lrck=1, sdata=0. Re-enable: lrck falls BCK_DIV clk after the first bck rise. The held pair is transmitted complete.
- resetn pulsed low mid-frame asynchronously, with no clk edge: outputs reach reset values immediately and in_ready=1.
- BCK_DIV=2, SLOT_BITS=24: bck period 4 clk, lrck period 192 clk, MSB one BCK after each lrck edge.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S playback types: default sample/slot widths, stereo pair layout, slot encoding.
package i2s_pkg;

  localparam int   I2S_DATA_BITS  = 16;
  localparam int   I2S_SLOT_BITS  = 32;
  localparam logic I2S_LEFT_LEVEL = 1'b0;

  typedef struct packed {
    logic [I2S_DATA_BITS-1:0] left;
    logic [I2S_DATA_BITS-1:0] right;
  } stereo_sample_t;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit clock / word select generator with per-slot bit counter.
// Latency: first bck rise BCK_DIV clk after tx_en, first fall event (left slot, b=0) BCK_DIV clk later.
// Backpressure: none; free-running while tx_en=1, everything returns to idle the clk after tx_en drops.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int   BCK_DIV    = 4,
  parameter int   SLOT_BITS  = I2S_SLOT_BITS,
  parameter logic LEFT_LEVEL = I2S_LEFT_LEVEL,
  parameter int   BIT_W      = $clog2(SLOT_BITS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tx_en,
  output logic             bck,
  output logic             lrck,
  output logic             fall_evt,
  output logic [BIT_W-1:0] bit_idx,
  output slot_e            slot
);

  localparam int DIV_W = $clog2(BCK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_q;
  slot_e            slot_q;
  logic             running;
  logic             wrap;

  assign wrap     = tx_en & (div_cnt == DIV_W'(BCK_DIV - 1));
  assign fall_evt = wrap & bck;

  // bit_idx/slot are the values that take effect at this fall event
  always_comb begin
    bit_idx = bit_q;
    slot    = slot_q;
    if (!running) begin
      bit_idx = '0;
      slot    = SLOT_LEFT;
    end else if (bit_q == BIT_W'(SLOT_BITS - 1)) begin
      bit_idx = '0;
      slot    = (slot_q == SLOT_LEFT) ? SLOT_RIGHT : SLOT_LEFT;
    end else begin
      bit_idx = bit_q + BIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      bck     <= 1'b0;
      lrck    <= ~LEFT_LEVEL;
      running <= 1'b0;
      bit_q   <= '0;
      slot_q  <= SLOT_LEFT;
    end else if (!tx_en) begin
      div_cnt <= '0;
      bck     <= 1'b0;
      lrck    <= ~LEFT_LEVEL;
      running <= 1'b0;
      bit_q   <= '0;
      slot_q  <= SLOT_LEFT;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
      if (wrap) bck <= ~bck;
      if (fall_evt) begin
        running <= 1'b1;
        bit_q   <= bit_idx;
        slot_q  <= slot;
        lrck    <= (slot == SLOT_LEFT) ? LEFT_LEVEL : ~LEFT_LEVEL;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_stereo16.sv
// I2S master transmitter, 16-bit stereo, Philips one-BCK delay; I2S_TX_HOLD_LAST_EN repeats the last pair on underrun.
// Latency: a held pair leaves MSB-first one BCK after the next left-slot lrck edge.
// Backpressure: one-entry holding register; in_ready stays low from accept until the next frame load.
module i2s_tx_stereo16
  import i2s_pkg::*;
#(
  parameter int   BCK_DIV    = 4,
  parameter int   SLOT_BITS  = I2S_SLOT_BITS,
  parameter int   DATA_BITS  = I2S_DATA_BITS,
  parameter logic LEFT_LEVEL = I2S_LEFT_LEVEL
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 tx_en,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_left,
  input  logic [DATA_BITS-1:0] in_right,
  output logic                 in_ready,
  output logic                 bck,
  output logic                 lrck,
  output logic                 sdata,
  output logic                 frame_load,
  output logic                 underrun
);

  localparam int BIT_W  = $clog2(SLOT_BITS);
  localparam int PAIR_W = 2 * DATA_BITS;

  logic                 fall_evt;
  logic [BIT_W-1:0]     bit_idx;
  slot_e                slot;
  logic [DATA_BITS-1:0] hold_left;
  logic [DATA_BITS-1:0] hold_right;
  logic                 hold_vld;
  logic                 accept;
  logic                 load;
  logic [PAIR_W-1:0]    shreg;
  logic [PAIR_W-1:0]    fill;

  i2s_clk_gen #(
    .BCK_DIV    (BCK_DIV),
    .SLOT_BITS  (SLOT_BITS),
    .LEFT_LEVEL (LEFT_LEVEL),
    .BIT_W      (BIT_W)
  ) u_clk_gen (
    .clk      (clk),
    .resetn   (resetn),
    .tx_en    (tx_en),
    .bck      (bck),
    .lrck     (lrck),
    .fall_evt (fall_evt),
    .bit_idx  (bit_idx),
    .slot     (slot)
  );

  assign in_ready = ~hold_vld;
  assign accept   = in_valid & ~hold_vld;
  assign load     = fall_evt & (bit_idx == '0) & (slot == SLOT_LEFT);

`ifdef I2S_TX_HOLD_LAST_EN
  logic [PAIR_W-1:0] last_pair;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               last_pair <= '0;
    else if (load && hold_vld) last_pair <= {hold_left, hold_right};
  end

  assign fill = last_pair;
`else
  assign fill = '0;
`endif

  // an accept coinciding with an empty-register load still waits for the next frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_vld   <= 1'b0;
      hold_left  <= '0;
      hold_right <= '0;
      frame_load <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_load <= load & hold_vld;
      underrun   <= load & ~hold_vld;
      if (accept) begin
        hold_left  <= in_left;
        hold_right <= in_right;
        hold_vld   <= 1'b1;
      end else if (load) begin
        hold_vld   <= 1'b0;
      end
    end
  end

  // left then right shift out of one register: after 16 left bits the right word is on top
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg <= '0;
      sdata <= 1'b0;
    end else if (!tx_en) begin
      shreg <= '0;
      sdata <= 1'b0;
    end else if (fall_evt) begin
      sdata <= 1'b0;
      if (load) begin
        shreg <= hold_vld ? {hold_left, hold_right} : fill;
      end else if ((bit_idx != '0) && (bit_idx <= BIT_W'(DATA_BITS))) begin
        sdata <= shreg[PAIR_W-1];
        shreg <= {shreg[PAIR_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_stereo16.sv
// Directed bench for i2s_tx_stereo16: bck-rise decoder feeds a frame scoreboard.
module tb_i2s_tx_stereo16;
  import i2s_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tx_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        in_ready, bck, lrck, sdata, frame_load, underrun;

  logic        tx_en2 = 1'b0;
  logic        in_valid2 = 1'b0;
  logic [15:0] in_left2 = '0;
  logic [15:0] in_right2 = '0;
  logic        in_ready2, bck2, lrck2, sdata2, frame_load2, underrun2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fl_cnt = 0;
  int ur_cnt = 0;
  stereo_sample_t exp_q[$];
  logic m_act = 1'b0;
  logic m_left = 1'b0;
  int   mb = 0;

  i2s_tx_stereo16 dut (
    .clk(clk), .resetn(resetn), .tx_en(tx_en), .in_valid(in_valid),
    .in_left(in_left), .in_right(in_right), .in_ready(in_ready),
    .bck(bck), .lrck(lrck), .sdata(sdata),
    .frame_load(frame_load), .underrun(underrun)
  );

  i2s_tx_stereo16 #(.BCK_DIV(2), .SLOT_BITS(24)) dut2 (
    .clk(clk), .resetn(resetn), .tx_en(tx_en2), .in_valid(in_valid2),
    .in_left(in_left2), .in_right(in_right2), .in_ready(in_ready2),
    .bck(bck2), .lrck(lrck2), .sdata(sdata2),
    .frame_load(frame_load2), .underrun(underrun2)
  );

  always #5 clk = ~clk;

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(negedge clk);
    if (frame_load) fl_cnt++;
    if (underrun) ur_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decoder: bit index b counted on bck rises, slot start seen as an lrck change
  initial begin : monitor
    logic bck_p, lrck_p, pad_bad;
    logic [15:0] wl, wr;
    stereo_sample_t e;
    bck_p = 1'b0; lrck_p = 1'b1; pad_bad = 1'b0; wl = '0; wr = '0;
    forever begin
      @(negedge clk);
      if (!resetn || !tx_en) begin
        m_act = 1'b0;
        lrck_p = 1'b1;
      end else if (bck && !bck_p) begin
        if (lrck != lrck_p) begin
          mb = 0;
          m_left = (lrck == 1'b0);
          if (m_left) begin m_act = 1'b1; wl = '0; wr = '0; pad_bad = 1'b0; end
          if (sdata) pad_bad = 1'b1;
        end else begin
          mb++;
          if (mb <= 16) begin
            if (m_left) wl = {wl[14:0], sdata};
            else        wr = {wr[14:0], sdata};
          end else if (sdata) begin
            pad_bad = 1'b1;
          end
          if (m_act && !m_left && mb == 31) begin
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("frame_data", {wl, wr}, e);
              chk("frame_pad", {31'b0, pad_bad}, 32'd0);
            end
            m_act = 1'b0;
          end
        end
        lrck_p = lrck;
      end
      bck_p = bck;
    end
  end

  task automatic push_exp(input logic [15:0] l, input logic [15:0] r);
    stereo_sample_t s;
    s.left = l; s.right = r;
    exp_q.push_back(s);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] l, input logic [15:0] r, input logic push, output int acc);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; in_left = l; in_right = r;
    if (push) push_exp(l, r);
    for (int n = 0; n < 1500 && !got; n++) begin
      if (in_ready) got = 1'b1;
      @(negedge clk);
    end
    acc = cyc;
    chk("accept", {31'b0, got}, 32'd1);
    chk("ready_fall", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic wait_q_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    chk(tag, {31'b0, exp_q.size() == 0}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_rise2(input string tag);
    logic p, hit;
    int n;
    p = bck2; hit = 1'b0; n = 0;
    while (!hit && n < 50) begin
      @(negedge clk);
      hit = bck2 && !p;
      p = bck2;
      n++;
    end
    chk(tag, {31'b0, hit}, 32'd1);
  endtask

  initial begin
    int a1, a2, a3, a4, fl0, ur0, t0, tr, tf, c0, c1, c2, r1, r2, n;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_bck", {31'b0, bck}, 32'd0);
    chk("rst_lrck", {31'b0, lrck}, 32'd1);
    chk("rst_sdata", {31'b0, sdata}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_frame_load", {31'b0, frame_load}, 32'd0);
    chk("rst_underrun", {31'b0, underrun}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // single pair
    fl0 = fl_cnt; ur0 = ur_cnt;
    send(16'hA5C3, 16'h0F0F, 1'b1, a1);
    in_valid = 1'b0;
    tx_en = 1'b1;
    wait_q_empty("t1_frame_seen", 1200);
    tx_en = 1'b0;
    chk("t1_frame_loads", fl_cnt - fl0, 32'd1);
    chk("t1_underruns", ur_cnt - ur0, 32'd0);
    chk("t1_ready_back", {31'b0, in_ready}, 32'd1);
    repeat (4) @(negedge clk);

    // back-to-back stream, in_valid held high
    fl0 = fl_cnt; ur0 = ur_cnt;
    send(16'h8001, 16'h7FFE, 1'b1, a1);
    tx_en = 1'b1;
    send(16'h1234, 16'hFEDC, 1'b1, a2);
    send(16'hFFFF, 16'h0000, 1'b1, a3);
    send(16'h0001, 16'h8000, 1'b1, a4);
    in_valid = 1'b0;
    chk("t2_accept_gap_a", a3 - a2, 32'd512);
    chk("t2_accept_gap_b", a4 - a3, 32'd512);
    wait_q_empty("t2_frames_seen", 2200);
    tx_en = 1'b0;
    chk("t2_frame_loads", fl_cnt - fl0, 32'd4);
    chk("t2_underruns", ur_cnt - ur0, 32'd0);
    repeat (4) @(negedge clk);

    // underrun after one frame
    fl0 = fl_cnt; ur0 = ur_cnt;
    send(16'hA5C3, 16'h0F0F, 1'b1, a1);
    in_valid = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
    push_exp(16'hA5C3, 16'h0F0F);
`else
    push_exp(16'h0000, 16'h0000);
`endif
    tx_en = 1'b1;
    wait_q_empty("t3_frames_seen", 1300);
    tx_en = 1'b0;
    chk("t3_frame_loads", fl_cnt - fl0, 32'd1);
    chk("t3_underruns", ur_cnt - ur0, 32'd1);
    repeat (4) @(negedge clk);

    // tx_en dropped at left bit 7, then re-enabled
    fl0 = fl_cnt; ur0 = ur_cnt;
    send(16'h1357, 16'h2468, 1'b0, a1);
    tx_en = 1'b1;
    send(16'h9ABC, 16'hDEF0, 1'b1, a2);
    in_valid = 1'b0;
    n = 0;
    while (!(m_act && m_left && mb == 7) && n < 600) begin @(posedge clk); n++; end
    chk("t4_reach_bit7", {31'b0, (m_act && m_left && mb == 7)}, 32'd1);
    @(negedge clk);
    tx_en = 1'b0;
    @(posedge clk); #1;
    chk("t4_off_bck", {31'b0, bck}, 32'd0);
    chk("t4_off_lrck", {31'b0, lrck}, 32'd1);
    chk("t4_off_sdata", {31'b0, sdata}, 32'd0);
    chk("t4_hold_kept", {31'b0, in_ready}, 32'd0);
    repeat (4) @(negedge clk);
    tx_en = 1'b1;
    t0 = cyc;
    n = 0;
    while (!bck && n < 100) begin @(negedge clk); n++; end
    tr = cyc;
    while (lrck && n < 100) begin @(negedge clk); n++; end
    tf = cyc;
    chk("t4_first_bck_rise", tr - t0, 32'd4);
    chk("t4_lrck_fall", tf - tr, 32'd4);
    wait_q_empty("t4_frame_seen", 1200);
    tx_en = 1'b0;
    chk("t4_frame_loads", fl_cnt - fl0, 32'd2);
    chk("t4_underruns", ur_cnt - ur0, 32'd0);
    repeat (4) @(negedge clk);

    // asynchronous reset mid-frame
    send(16'h0001, 16'h0002, 1'b0, a1);
    tx_en = 1'b1;
    send(16'h0003, 16'h0004, 1'b0, a2);
    in_valid = 1'b0;
    repeat (90) @(negedge clk);
    @(posedge clk); #3;
    chk("t5_pre_lrck", {31'b0, lrck}, 32'd0);
    chk("t5_pre_ready", {31'b0, in_ready}, 32'd0);
    resetn = 1'b0;
    tx_en = 1'b0;
    #1;
    chk("t5_bck", {31'b0, bck}, 32'd0);
    chk("t5_lrck", {31'b0, lrck}, 32'd1);
    chk("t5_sdata", {31'b0, sdata}, 32'd0);
    chk("t5_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t5_frame_load", {31'b0, frame_load}, 32'd0);
    chk("t5_underrun", {31'b0, underrun}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // BCK_DIV=2, SLOT_BITS=24 instance
    in_left2 = 16'h8001; in_right2 = 16'hC003; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("t6_accept", {31'b0, in_ready2}, 32'd0);
    tx_en2 = 1'b1;
    n = 0;
    while (lrck2 && n < 200) begin @(negedge clk); n++; end
    c0 = cyc;
    wait_rise2("t6_rise_b0");
    chk("t6_left_b0", {31'b0, sdata2}, 32'd0);
    wait_rise2("t6_rise_b1");
    r1 = cyc;
    chk("t6_left_msb", {31'b0, sdata2}, 32'd1);
    wait_rise2("t6_rise_b2");
    r2 = cyc;
    chk("t6_bck_period", r2 - r1, 32'd4);
    n = 0;
    while (!lrck2 && n < 300) begin @(negedge clk); n++; end
    c1 = cyc;
    chk("t6_slot_len", c1 - c0, 32'd96);
    wait_rise2("t6_rise_rb0");
    chk("t6_right_b0", {31'b0, sdata2}, 32'd0);
    wait_rise2("t6_rise_rb1");
    chk("t6_right_msb", {31'b0, sdata2}, 32'd1);
    n = 0;
    while (lrck2 && n < 300) begin @(negedge clk); n++; end
    c2 = cyc;
    chk("t6_lrck_period", c2 - c0, 32'd192);
    tx_en2 = 1'b0;
    repeat (2) @(negedge clk);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
